// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch front end: PC, single-outstanding imem fetch, valid/ready instruction port
module instr_fetch_unit #(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [31:0]     instr_out,
   output logic [XLEN-1:0] instr_pc,
   output logic [6:0]      opcode,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            misalign_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_HOLD
   } state_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] fpc_q, fpc_d;
   logic            kill_q, kill_d;
   logic [31:0]     instr_out_q, instr_out_d;
   logic [XLEN-1:0] instr_pc_q, instr_pc_d;
   logic            misalign_q, misalign_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         fpc_q       <= RESET_PC;
         kill_q      <= 1'b0;
         instr_out_q <= NOP;
         instr_pc_q  <= '0;
         misalign_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         fpc_q       <= fpc_d;
         kill_q      <= kill_d;
         instr_out_q <= instr_out_d;
         instr_pc_q  <= instr_pc_d;
         misalign_q  <= misalign_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      fpc_d       = fpc_q;
      kill_d      = kill_q;
      instr_out_d = instr_out_q;
      instr_pc_d  = instr_pc_q;
      misalign_d  = redirect && (redirect_pc[1:0] != 2'b00);

      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            if (imem_gnt) begin
               fpc_d   = pc_q;
               pc_d    = pc_q + XLEN'(4);
               state_d = S_WAIT;
               if (redirect) kill_d = 1'b1;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               kill_d  = 1'b0;
               state_d = S_FETCH;
               if (!kill_q && !redirect) begin
                  instr_out_d = imem_rdata;
                  instr_pc_d  = fpc_q;
                  state_d     = S_HOLD;
               end
            end else if (redirect) begin
               kill_d = 1'b1;
            end
         end
         S_HOLD: begin
            // a redirect and an accepted transfer both leave HOLD for the next fetch
            if (redirect || instr_ready) state_d = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase

      if (redirect) pc_d = {redirect_pc[XLEN-1:2], 2'b00};
   end

   assign imem_req     = (state_q == S_FETCH);
   assign imem_addr    = pc_q;
   assign instr_valid  = (state_q == S_HOLD) && !redirect;
   assign instr_out    = instr_out_q;
   assign instr_pc     = instr_pc_q;
   assign opcode       = instr_out_q[6:0];
   assign misalign_err = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr_out;
   logic [63:0] instr_pc;
   logic [6:0]  opcode;
   logic        redirect = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic        misalign_err;

   int n_checks = 0;
   int n_errors = 0;

   // memory model state: one pending response, delivered lat cycles after grant
   logic        pend = 1'b0;
   logic [63:0] pend_addr = '0;
   int          wait_cnt = 0;
   int          lat = 1;
   logic        ovr_en = 1'b0;
   logic [31:0] ovr_data = '0;

   instr_fetch_unit #(.XLEN(64), .RESET_PC(64'h0)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr_out   (instr_out),
      .instr_pc    (instr_pc),
      .opcode      (opcode),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .misalign_err(misalign_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return ({a[23:0], 8'h00} | {25'h0, a[8:2]}) ^ 32'h0000_0033;
   endfunction

   // drive memory inputs for the coming posedge, then advance to the next negedge
   task automatic cyc();
      logic        give_rv;
      logic        nxt_pend;
      logic [63:0] nxt_addr;
      int          nxt_cnt;
      give_rv  = pend && (wait_cnt == 1);
      imem_rvalid = give_rv;
      imem_rdata  = ovr_en ? ovr_data : mem_word(pend_addr);
      imem_gnt    = imem_req && !pend;
      nxt_pend = pend;
      nxt_addr = pend_addr;
      nxt_cnt  = wait_cnt;
      if (give_rv) nxt_pend = 1'b0;
      else if (pend) nxt_cnt = wait_cnt - 1;
      if (imem_gnt) begin
         nxt_pend = 1'b1;
         nxt_addr = imem_addr;
         nxt_cnt  = lat;
      end
      @(negedge clk);
      pend      = nxt_pend;
      pend_addr = nxt_addr;
      wait_cnt  = nxt_cnt;
      redirect  = 1'b0;
      ovr_en    = 1'b0;
      imem_gnt  = 1'b0;
      imem_rvalid = 1'b0;
      #1;
   endtask

   task automatic expect_hold(input string name, input logic [63:0] pc);
      logic [31:0] w;
      w = mem_word(pc);
      n_checks++;
      if (instr_valid !== 1'b1 || instr_pc !== pc || instr_out !== w || opcode !== w[6:0]) begin
         n_errors++;
         $display("FAIL %s: valid=%0b pc=%h out=%h op=%h, expected valid=1 pc=%h out=%h op=%h",
                  name, instr_valid, instr_pc, instr_out, opcode, pc, w, w[6:0]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      pend = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr_out !== 32'h13 ||
          instr_pc !== 64'h0 || misalign_err !== 1'b0 || opcode !== 7'h13) begin
         n_errors++;
         $display("FAIL reset: req=%0b valid=%0b out=%h pc=%h mis=%0b op=%h, expected 0 0 00000013 0 0 13",
                  imem_req, instr_valid, instr_out, instr_pc, misalign_err, opcode);
      end
   endtask

   task automatic test_sequential();
      logic [63:0] exp_pc;
      exp_pc = 64'h0;
      instr_ready = 1'b1;
      lat = 1;
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         n_checks++;
         if (instr_valid !== (i % 3 == 2)) begin
            n_errors++;
            $display("FAIL seq_valid[%0d]: valid=%0b, expected %0b", i, instr_valid, (i % 3 == 2));
         end
         if (i % 3 == 2) begin
            expect_hold("seq_data", exp_pc);
            exp_pc = exp_pc + 64'h4;
         end
      end
   endtask

   task automatic test_backpressure();
      instr_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         expect_hold("bp_hold", 64'hC);
         n_checks++;
         if (imem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_req: req=%0b, expected 0", imem_req);
         end
      end
      instr_ready = 1'b1;
      cyc();
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 64'h10) begin
         n_errors++;
         $display("FAIL bp_next: req=%0b addr=%h, expected 1 0000000000000010", imem_req, imem_addr);
      end
      cyc();
      cyc();
      expect_hold("bp_deliver", 64'h10);
   endtask

   task automatic test_redirect_wait();
      cyc();
      lat = 3;
      cyc();
      redirect = 1'b1;
      redirect_pc = 64'h100;
      ovr_en = 1'b1;
      ovr_data = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) begin
            ovr_en = 1'b1;
            ovr_data = 32'hDEAD_BEEF;
         end
         cyc();
         n_checks++;
         if (instr_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rw_killed[%0d]: valid=%0b, expected 0", i, instr_valid);
         end
      end
      lat = 1;
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 64'h100 || misalign_err !== 1'b0) begin
         n_errors++;
         $display("FAIL rw_refetch: req=%0b addr=%h mis=%0b, expected 1 0000000000000100 0",
                  imem_req, imem_addr, misalign_err);
      end
      cyc();
      cyc();
      expect_hold("rw_deliver", 64'h100);
   endtask

   task automatic test_redirect_hold();
      instr_ready = 1'b1;
      redirect = 1'b1;
      redirect_pc = 64'h200;
      #1;
      n_checks++;
      if (instr_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL rh_valid: valid=%0b, expected 0", instr_valid);
      end
      cyc();
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 64'h200) begin
         n_errors++;
         $display("FAIL rh_fetch: req=%0b addr=%h, expected 1 0000000000000200", imem_req, imem_addr);
      end
      cyc();
      cyc();
      expect_hold("rh_deliver", 64'h200);
   endtask

   task automatic test_misalign_wrap();
      redirect = 1'b1;
      redirect_pc = 64'h203;
      cyc();
      n_checks++;
      if (misalign_err !== 1'b1 || imem_addr !== 64'h200) begin
         n_errors++;
         $display("FAIL mis_pulse: mis=%0b addr=%h, expected 1 0000000000000200", misalign_err, imem_addr);
      end
      cyc();
      n_checks++;
      if (misalign_err !== 1'b0) begin
         n_errors++;
         $display("FAIL mis_clear: mis=%0b, expected 0", misalign_err);
      end
      cyc();
      expect_hold("mis_deliver", 64'h200);
      redirect = 1'b1;
      redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      cyc();
      cyc();
      cyc();
      expect_hold("wrap_top", 64'hFFFF_FFFF_FFFF_FFFC);
      cyc();
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
         n_errors++;
         $display("FAIL wrap_addr: req=%0b addr=%h, expected 1 0000000000000000", imem_req, imem_addr);
      end
      cyc();
      cyc();
      expect_hold("wrap_deliver", 64'h0);
   endtask

   task automatic test_async_reset();
      lat = 4;
      cyc();
      cyc();
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr_out !== 32'h13 || instr_pc !== 64'h0) begin
         n_errors++;
         $display("FAIL areset: req=%0b valid=%0b out=%h pc=%h, expected 0 0 00000013 0",
                  imem_req, instr_valid, instr_out, instr_pc);
      end
      pend = 1'b0;
      lat = 1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      cyc();
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
         n_errors++;
         $display("FAIL areset_refetch: req=%0b addr=%h, expected 1 0000000000000000", imem_req, imem_addr);
      end
      cyc();
      cyc();
      expect_hold("areset_deliver", 64'h0);
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect_wait();
      test_redirect_hold();
      test_misalign_wrap();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
